// File: rtl/ide_pkg.sv
// Shared IDE sector-path constants: default RAM geometry and port identifiers
// used by the arbiter and the sequencers around it.
package ide_pkg;

  localparam int IDE_ADDR_W = 8;
  localparam int IDE_DATA_W = 16;

  localparam logic PORT_HOST = 1'b0;
  localparam logic PORT_MCU  = 1'b1;

  localparam logic [7:0] SECTOR_LAST = 8'hff;

endpackage

// File: rtl/sector_ram_arbiter.sv
// Single-port-per-cycle arbiter for the 256x16 sector RAM shared by the host
// data-register path and the MCU SPI path; busy flag selects the priority port.
module sector_ram_arbiter
  import ide_pkg::*;
#(
  parameter int ADDR_W       = IDE_ADDR_W,
  parameter int DATA_W       = IDE_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              owner_mcu,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_last,
  input  logic              mcu_req,
  input  logic              mcu_we,
  input  logic [ADDR_W-1:0] mcu_addr,
  input  logic [DATA_W-1:0] mcu_wdata,
  output logic              mcu_ack,
  output logic              mcu_rvalid,
  output logic [DATA_W-1:0] mcu_rdata,
  output logic              mcu_last,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Handshake: a requester holds req/we/addr/wdata until it sees ack in the
  // same cycle; on that clock edge the access is committed and it may advance.
  // Read data is presented with a one-cycle rvalid pulse after the ack.

  localparam logic [3:0]        LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  logic              owner_q;
  logic [3:0]        starve_cnt;
  logic              rd_valid;
  logic              rd_owner;
  logic [DATA_W-1:0] host_rd_q;
  logic [DATA_W-1:0] mcu_rd_q;

  logic              owner_changed;
  logic [3:0]        starve_eff;
  logic              owner_req;
  logic              other_req;
  logic              grant_owner;
  logic              grant_other;
  logic              gnt_host;
  logic              gnt_mcu;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A fresh owner starts with a clean count even before starve_cnt clears.
  assign owner_changed = (owner_mcu != owner_q);
  assign starve_eff    = owner_changed ? 4'd0 : starve_cnt;

  always_comb begin
    owner_req   = owner_mcu ? mcu_req  : host_req;
    other_req   = owner_mcu ? host_req : mcu_req;
    grant_owner = !reset && owner_req && !(other_req && (starve_eff == LIMIT));
    grant_other = !reset && other_req && !grant_owner;
    gnt_mcu     = owner_mcu ? grant_owner : grant_other;
    gnt_host    = owner_mcu ? grant_other : grant_owner;
  end

  always_comb begin
    sel_we    = gnt_mcu ? mcu_we    : host_we;
    sel_addr  = gnt_mcu ? mcu_addr  : host_addr;
    sel_wdata = gnt_mcu ? mcu_wdata : host_wdata;
    ram_we    = (gnt_host || gnt_mcu) && sel_we;
    ram_re    = (gnt_host || gnt_mcu) && !sel_we;
    ram_waddr = sel_addr;
    ram_raddr = sel_addr;
    ram_wdata = sel_wdata;
  end

  assign host_ack  = gnt_host;
  assign mcu_ack   = gnt_mcu;
  assign host_last = gnt_host && (host_addr == TOP_ADDR);
  assign mcu_last  = gnt_mcu && (mcu_addr == TOP_ADDR);

  // RAM output is live during the rvalid cycle; the per-port copy holds it after.
  assign host_rvalid = !reset && rd_valid && (rd_owner == PORT_HOST);
  assign mcu_rvalid  = !reset && rd_valid && (rd_owner == PORT_MCU);
  assign host_rdata  = reset ? '0 : (host_rvalid ? ram_rdata : host_rd_q);
  assign mcu_rdata   = reset ? '0 : (mcu_rvalid ? ram_rdata : mcu_rd_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q    <= 1'b0;
      starve_cnt <= 4'd0;
      rd_valid   <= 1'b0;
      rd_owner   <= PORT_HOST;
      host_rd_q  <= '0;
      mcu_rd_q   <= '0;
    end else begin
      owner_q  <= owner_mcu;
      rd_valid <= ram_re;
      if (ram_re) rd_owner <= gnt_mcu ? PORT_MCU : PORT_HOST;
      if (host_rvalid) host_rd_q <= ram_rdata;
      if (mcu_rvalid) mcu_rd_q <= ram_rdata;
      if (owner_changed || !other_req || grant_other) starve_cnt <= 4'd0;
      else if (grant_owner && (starve_cnt != LIMIT)) starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_sector_ram_arbiter.sv
// Self-checking bench for sector_ram_arbiter with a behavioural sector RAM,
// a grant vector table and hand-written multi-cycle sequences.
module tb_sector_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          owner_mcu = 1'b0;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack, host_rvalid, host_last;
  logic [DW-1:0] host_rdata;
  logic          mcu_req = 1'b0, mcu_we = 1'b0;
  logic [AW-1:0] mcu_addr = '0;
  logic [DW-1:0] mcu_wdata = '0;
  logic          mcu_ack, mcu_rvalid, mcu_last;
  logic [DW-1:0] mcu_rdata;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic          ram_re, ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  sector_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .owner_mcu(owner_mcu),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_last(host_last),
    .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_wdata(mcu_wdata),
    .mcu_ack(mcu_ack), .mcu_rvalid(mcu_rvalid), .mcu_rdata(mcu_rdata), .mcu_last(mcu_last),
    .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_waddr(ram_waddr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // clock / reset / RAM model
  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  // scoreboard
  logic [DW-1:0] host_q[$];
  logic [DW-1:0] mcu_q[$];
  logic [DW-1:0] shadow [256];
  int pass_cnt = 0;
  int total_cnt = 0;
  int mcu_rv_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (host_rvalid) begin
        if (host_q.size() == 0) chk("host_rvalid_unexpected", 1, 0);
        else chk("host_rdata", host_rdata, host_q.pop_front());
      end
      if (mcu_rvalid) begin
        mcu_rv_cnt++;
        if (mcu_q.size() == 0) chk("mcu_rvalid_unexpected", 1, 0);
        else chk("mcu_rdata", mcu_rdata, mcu_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic drive(input logic own,
                       input logic hr, input logic hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                       input logic mr, input logic mw, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    owner_mcu = own;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    mcu_req = mr;  mcu_we = mw;  mcu_addr = ma;  mcu_wdata = md;
  endtask

  // Called at the negedge: checks grants/lasts, books the expected effect, steps past posedge.
  task automatic cycle_chk(input string name, input bit eh, input bit em, input bit elh, input bit elm);
    chk({name, "_host_ack"}, host_ack, eh);
    chk({name, "_mcu_ack"}, mcu_ack, em);
    chk({name, "_host_last"}, host_last, elh);
    chk({name, "_mcu_last"}, mcu_last, elm);
    if (eh) begin
      if (host_we) shadow[host_addr] = host_wdata;
      else host_q.push_back(shadow[host_addr]);
    end
    if (em) begin
      if (mcu_we) shadow[mcu_addr] = mcu_wdata;
      else mcu_q.push_back(shadow[mcu_addr]);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      host_req = 1'b0; mcu_req = 1'b0;
      @(negedge clk);
      cycle_chk("idle", 0, 0, 0, 0);
    end
  endtask

  typedef struct {
    logic own;
    logic hr, hw; logic [AW-1:0] ha;
    logic mr, mw; logic [AW-1:0] ma;
    bit eh, em, ere, ewe, elh, elm;
    logic [AW-1:0] eaddr;
  } vec_t;

  vec_t vecs [8];
  int stall, max_stall, rv_base;
  logic [DW-1:0] d;

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = '0; shadow[i] = '0; end

    // reset state, with a request held to show no grant leaks out
    host_req = 1'b1; mcu_req = 1'b1; mcu_we = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_mcu_ack", mcu_ack, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_rvalid", {host_rvalid, mcu_rvalid}, 0);
    chk("rst_rdata", {host_rdata, mcu_rdata}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // grant vector table
    vecs[0] = '{0, 1,1,8'h01, 0,0,8'h00, 1,0,0,1,0,0, 8'h01};
    vecs[1] = '{0, 0,0,8'h00, 1,1,8'h02, 0,1,0,1,0,0, 8'h02};
    vecs[2] = '{0, 1,0,8'h01, 1,1,8'h03, 1,0,1,0,0,0, 8'h01};
    vecs[3] = '{1, 1,1,8'h04, 1,0,8'h02, 0,1,1,0,0,0, 8'h02};
    vecs[4] = '{1, 1,0,8'hff, 0,0,8'h00, 1,0,1,0,1,0, 8'hff};
    vecs[5] = '{0, 0,0,8'h00, 1,0,8'hff, 0,1,1,0,0,1, 8'hff};
    vecs[6] = '{0, 0,0,8'h00, 0,0,8'h00, 0,0,0,0,0,0, 8'h00};
    vecs[7] = '{1, 1,1,8'hff, 1,1,8'hfe, 0,1,0,1,0,0, 8'hfe};
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].own, vecs[i].hr, vecs[i].hw, vecs[i].ha, 16'ha000 | 16'(i),
            vecs[i].mr, vecs[i].mw, vecs[i].ma, 16'hb000 | 16'(i));
      @(negedge clk);
      chk($sformatf("vec%0d_ram_re", i), ram_re, vecs[i].ere);
      chk($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].ewe);
      if (vecs[i].ere) chk($sformatf("vec%0d_raddr", i), ram_raddr, vecs[i].eaddr);
      if (vecs[i].ewe) chk($sformatf("vec%0d_waddr", i), ram_waddr, vecs[i].eaddr);
      cycle_chk($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em, vecs[i].elh, vecs[i].elm);
      idle(1);
    end

    // host alone: write 0x1234 @0x05 then read it back
    owner_mcu = 1'b0;
    idle(1);
    drive(0, 1,1,8'h05,16'h1234, 0,0,8'h00,16'h0);
    @(negedge clk);
    chk("t1_wdata", ram_wdata, 16'h1234);
    chk("t1_waddr", ram_waddr, 8'h05);
    cycle_chk("t1_wr", 1, 0, 0, 0);
    drive(0, 1,0,8'h05,16'h0, 0,0,8'h00,16'h0);
    @(negedge clk);
    cycle_chk("t1_rd", 1, 0, 0, 0);
    idle(3);
    chk("t1_host_rdata_hold", host_rdata, 16'h1234);
    chk("t1_mcu_rdata_zero", mcu_rdata, 16'h0);

    // starvation: both request, MCU owns -> M,M,M,M,H repeating
    owner_mcu = 1'b1;
    idle(1);
    stall = 0; max_stall = 0;
    for (int i = 0; i < 15; i++) begin
      drive(1, 1,1,8'h20,16'h2000 | 16'(i), 1,1,8'h40,16'h4000 | 16'(i));
      @(negedge clk);
      if (host_ack) stall = 0;
      else stall++;
      if (stall > max_stall) max_stall = stall;
      cycle_chk($sformatf("starve%0d", i), (i % 5) == 4, (i % 5) != 4, 0, 0);
    end
    chk("starve_max_host_stall_le4", max_stall <= 4, 1);
    idle(1);

    // ownership toggle with a host read outstanding
    owner_mcu = 1'b0;
    drive(0, 1,1,8'h10,16'hbeef, 0,0,8'h00,16'h0);
    @(negedge clk); cycle_chk("t3_wr10", 1, 0, 0, 0);
    drive(0, 1,1,8'h11,16'hcafe, 0,0,8'h00,16'h0);
    @(negedge clk); cycle_chk("t3_wr11", 1, 0, 0, 0);
    drive(0, 1,0,8'h10,16'h0, 0,0,8'h00,16'h0);
    @(negedge clk); cycle_chk("t3_hrd", 1, 0, 0, 0);
    drive(1, 1,0,8'h10,16'h0, 1,0,8'h11,16'h0);
    @(negedge clk);
    chk("t3_toggle_raddr", ram_raddr, 8'h11);
    cycle_chk("t3_toggle", 0, 1, 0, 0);
    drive(1, 1,0,8'h10,16'h0, 0,0,8'h00,16'h0);
    @(negedge clk); cycle_chk("t3_hrd2", 1, 0, 0, 0);
    idle(2);
    chk("t3_mcu_rdata_hold", mcu_rdata, 16'hcafe);

    // MCU streams a full sector, then reads it back back-to-back
    owner_mcu = 1'b1;
    idle(1);
    for (int i = 0; i < 256; i++) begin
      d = 16'($urandom_range(0, 65535));
      drive(1, 0,0,8'h00,16'h0, 1,1,8'(i),d);
      @(negedge clk);
      cycle_chk("stream_wr", 0, 1, 0, i == 255);
    end
    rv_base = mcu_rv_cnt;
    for (int i = 0; i < 256; i++) begin
      drive(1, 0,0,8'h00,16'h0, 1,0,8'(i),16'h0);
      @(negedge clk);
      cycle_chk("stream_rd", 0, 1, 0, i == 255);
    end
    idle(2);
    chk("stream_rvalid_count", mcu_rv_cnt - rv_base, 256);

    // reset while a host read is in flight and both ports request
    owner_mcu = 1'b0;
    idle(1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1,1,8'h30,16'h3000, 1,1,8'h31,16'h3100);
      @(negedge clk); cycle_chk("pre_rst", 1, 0, 0, 0);
    end
    drive(0, 1,0,8'h10,16'h0, 1,1,8'h31,16'h3100);
    @(negedge clk);
    chk("pre_rst_rd_ack", host_ack, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_host_rvalid", host_rvalid, 0);
    chk("mid_rst_mcu_rvalid", mcu_rvalid, 0);
    chk("mid_rst_ram_re", ram_re, 0);
    chk("mid_rst_ram_we", ram_we, 0);
    chk("mid_rst_acks", {host_ack, mcu_ack}, 0);
    chk("mid_rst_host_rdata", host_rdata, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    // a cleared count gives the owner four grants before the MCU slot
    for (int i = 0; i < 5; i++) begin
      drive(0, 1,1,8'h30,16'h3000, 1,1,8'h31,16'h3100);
      @(negedge clk);
      cycle_chk($sformatf("post_rst%0d", i), i < 4, i == 4, 0, 0);
    end
    idle(3);

    chk("host_q_empty", host_q.size(), 0);
    chk("mcu_q_empty", mcu_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
